// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache in front of a 32-bit SRAM controller.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module cache_controller #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned TAG_BITS   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WR_EN,
    input  logic        RD_EN,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        sram_wr_en,
    output logic        sram_rd_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned SETS    = 1 << INDEX_BITS;
    localparam int unsigned TAG_LSB = 3 + INDEX_BITS;

    typedef enum logic [1:0] {IDLE, FILL0, FILL1, WRITE} state_t;

    state_t              r_state;
    logic [1:0]          r_valid [SETS];
    logic [SETS-1:0]     r_lru;
    logic [TAG_BITS-1:0] r_tag   [2][SETS];
    logic [31:0]         r_word0 [2][SETS];
    logic [31:0]         r_word1 [2][SETS];
    logic [31:0]         r_fill_word0;
    logic                r_post_fill;
`ifdef CACHE_STATS_EN
    logic [31:0]         r_hit_count;
    logic [31:0]         r_miss_count;
`endif

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_word_sel;
    logic                  w_hit0;
    logic                  w_hit1;
    logic                  w_hit;
    logic                  w_hit_way;
    logic                  w_victim;
    logic [31:0]           w_hit_word;

    assign w_index    = address[3 +: INDEX_BITS];
    assign w_tag      = address[TAG_LSB +: TAG_BITS];
    assign w_word_sel = address[2];

    assign w_hit0     = r_valid[w_index][0] && (r_tag[0][w_index] == w_tag);
    assign w_hit1     = r_valid[w_index][1] && (r_tag[1][w_index] == w_tag);
    assign w_hit      = w_hit0 || w_hit1;
    assign w_hit_way  = w_hit1;
    assign w_hit_word = w_word_sel ? r_word1[w_hit_way][w_index] : r_word0[w_hit_way][w_index];

    // Fill an empty way first (way0 before way1), otherwise evict the LRU way
    assign w_victim = !r_valid[w_index][0] ? 1'b0 :
                      !r_valid[w_index][1] ? 1'b1 : r_lru[w_index];

    assign sram_rd_en = (r_state == FILL0) || (r_state == FILL1);
    assign sram_wr_en = (r_state == WRITE);

    // Pipeline-facing and SRAM-facing datapath decode
    always_comb begin
        ready        = 1'b0;
        readData     = 32'h0;
        sram_address = 32'h0;
        sram_wdata   = 32'h0;
        case (r_state)
            IDLE: begin
                ready    = !WR_EN && (!RD_EN || w_hit);
                readData = w_hit ? w_hit_word : 32'h0;
            end
            FILL0:   sram_address = {address[31:3], 3'b000};
            FILL1:   sram_address = {address[31:3], 3'b100};
            WRITE: begin
                ready        = sram_ready;
                sram_address = address;
                sram_wdata   = writeData;
            end
            default: ready = 1'b0;
        endcase
    end

    // Control FSM, valid/LRU bookkeeping and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_valid      <= '{default: 2'b00};
            r_lru        <= '0;
            r_fill_word0 <= 32'h0;
            r_post_fill  <= 1'b0;
`ifdef CACHE_STATS_EN
            r_hit_count  <= 32'h0;
            r_miss_count <= 32'h0;
`endif
        end else begin
            r_post_fill <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (WR_EN) begin
                        if (w_hit) r_lru[w_index] <= ~w_hit_way;
                        r_state <= WRITE;
                    end else if (RD_EN) begin
                        if (w_hit) begin
                            r_lru[w_index] <= ~w_hit_way;
`ifdef CACHE_STATS_EN
                            if (!r_post_fill) r_hit_count <= r_hit_count + 32'd1;
`endif
                        end else begin
                            r_state <= FILL0;
`ifdef CACHE_STATS_EN
                            r_miss_count <= r_miss_count + 32'd1;
`endif
                        end
                    end
                end
                FILL0: begin
                    if (sram_ready) begin
                        r_fill_word0 <= sram_rdata;
                        r_state      <= FILL1;
                    end
                end
                FILL1: begin
                    if (sram_ready) begin
                        r_valid[w_index][w_victim] <= 1'b1;
                        r_lru[w_index]             <= ~w_victim;
                        r_post_fill                <= 1'b1;
                        r_state                    <= IDLE;
                    end
                end
                WRITE: begin
                    if (sram_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; validity is tracked separately
    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((r_state == IDLE) && WR_EN && w_hit) begin
                if (w_word_sel) r_word1[w_hit_way][w_index] <= writeData;
                else            r_word0[w_hit_way][w_index] <= writeData;
            end
            if ((r_state == FILL1) && sram_ready) begin
                r_tag[w_victim][w_index]   <= w_tag;
                r_word0[w_victim][w_index] <= r_fill_word0;
                r_word1[w_victim][w_index] <= sram_rdata;
            end
        end
    end

`ifdef CACHE_STATS_EN
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus random traffic against an LRU-list cache model
// and a word-addressed memory model. Define CACHE_STATS_EN to also check the hit/miss counters.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        WR_EN = 1'b0;
    logic        RD_EN = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] writeData = 32'h0;
    logic [31:0] readData;
    logic        ready;
    logic        sram_wr_en;
    logic        sram_rd_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'h0;
    logic        sram_ready = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .WR_EN        (WR_EN),
        .RD_EN        (RD_EN),
        .address      (address),
        .writeData    (writeData),
        .readData     (readData),
        .ready        (ready),
        .sram_wr_en   (sram_wr_en),
        .sram_rd_en   (sram_rd_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory model keyed by word address; unwritten words hold a hash of the address
    logic [31:0] mem [int unsigned];
    // Per-set recency list of resident tags, most recent first
    logic [9:0]  m_tag [64][2];
    int          m_cnt [64];
    int          m_hits;
    int          m_misses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int unsigned wa = 32'(a[18:2]);
        if (mem.exists(wa)) return mem[wa];
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int m_find(input logic [31:0] a);
        int unsigned s = 32'(a[8:3]);
        for (int i = 0; i < m_cnt[s]; i++)
            if (m_tag[s][i] == a[18:9]) return i;
        return -1;
    endfunction

    function automatic void m_touch(input logic [31:0] a);
        int unsigned s = 32'(a[8:3]);
        if (m_find(a) == 1) begin
            m_tag[s][1] = m_tag[s][0];
            m_tag[s][0] = a[18:9];
        end
    endfunction

    function automatic void m_fill(input logic [31:0] a);
        int unsigned s = 32'(a[8:3]);
        m_tag[s][1] = m_tag[s][0];
        m_tag[s][0] = a[18:9];
        if (m_cnt[s] < 2) m_cnt[s]++;
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < 64; s++) m_cnt[s] = 0;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    // Drive one cycle's inputs just after the falling edge, then settle before checking
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic sr, input logic [31:0] srd);
        @(negedge clk);
        RD_EN = rd; WR_EN = wr; address = a; writeData = wd; sram_ready = sr; sram_rdata = srd;
        #1;
    endtask

    task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
        check({tag, "_hits"}, hit_count, 32'(m_hits));
        check({tag, "_misses"}, miss_count, 32'(m_misses));
`else
        total = total + 0;
`endif
    endtask

    task automatic do_read(input logic [31:0] a, input int lat);
        logic        h = (m_find(a) >= 0);
        logic [31:0] line = {a[31:3], 3'b000};
        drive(1'b1, 1'b0, a, 32'h0, 1'b0, 32'h0);
        check("rd_req_ready", 32'(ready), 32'(h));
        check("rd_req_sram_en", 32'({sram_rd_en, sram_wr_en}), 32'h0);
        if (h) begin
            check("rd_hit_data", readData, mem_rd(a));
            m_touch(a);
            m_hits++;
        end else begin
            for (int ph = 0; ph < 2; ph++) begin
                for (int k = 1; k <= lat; k++) begin
                    drive(1'b1, 1'b0, a, 32'h0, k == lat,
                          (k == lat) ? mem_rd(line | 32'(ph * 4)) : 32'hDEAD_BEEF);
                    check("fill_rd_en", 32'({sram_rd_en, sram_wr_en}), 32'h2);
                    check("fill_addr", sram_address, line | 32'(ph * 4));
                    check("fill_ready", 32'(ready), 32'h0);
                end
            end
            m_fill(a);
            m_misses++;
            drive(1'b1, 1'b0, a, 32'h0, 1'b0, 32'h0);
            check("post_fill_ready", 32'(ready), 32'h1);
            check("post_fill_data", readData, mem_rd(a));
            check("post_fill_rd_en", 32'(sram_rd_en), 32'h0);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat, input logic rd);
        logic h = (m_find(a) >= 0);
        drive(rd, 1'b1, a, d, 1'b0, 32'h0);
        check("wr_req_ready", 32'(ready), 32'h0);
        check("wr_req_wr_en", 32'(sram_wr_en), 32'h0);
        if (h) m_touch(a);
        for (int k = 1; k <= lat; k++) begin
            drive(rd, 1'b1, a, d, k == lat, 32'h0);
            check("wr_en", 32'({sram_rd_en, sram_wr_en}), 32'h1);
            check("wr_addr", sram_address, a);
            check("wr_data", sram_wdata, d);
            check("wr_ready", 32'(ready), 32'(k == lat));
        end
        mem[32'(a[18:2])] = d;
    endtask

    task automatic idle_cycle(input logic spurious);
        drive(1'b0, 1'b0, 32'h0, 32'h0, spurious, 32'hFFFF_FFFF);
        check("idle_ready", 32'(ready), 32'h1);
        check("idle_sram_en", 32'({sram_rd_en, sram_wr_en}), 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'h1);
        check("rst_sram_en", 32'({sram_rd_en, sram_wr_en}), 32'h0);
        check("rst_sram_addr", sram_address, 32'h0);
        check_stats("rst");

        // Cold read, then hits on both words of the line
        mem[32'h100 >> 2] = 32'hAAAA_0000;
        mem[32'h104 >> 2] = 32'hBBBB_1111;
        do_read(32'h104, 2);
        check("cold_data", readData, 32'hBBBB_1111);
        check_stats("cold");
        do_read(32'h104, 1);
        do_read(32'h100, 1);
        check("hit_word0", readData, 32'hAAAA_0000);

        // LRU eviction within set 32
        do_read(32'h300, 2);
        do_read(32'h100, 1);
        do_read(32'h500, 1);
        do_read(32'h100, 1);
        do_read(32'h300, 1);

        // Write hit, write miss (with RD_EN also high), spurious sram_ready in IDLE
        do_write(32'h100, 32'h1234_5678, 3, 1'b0);
        do_read(32'h100, 1);
        check("wr_hit_readback", readData, 32'h1234_5678);
        do_write(32'h900, 32'hCAFE_F00D, 2, 1'b1);
        do_read(32'h900, 1);
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        check_stats("mid");

        // Reset while the second fill beat is outstanding
        drive(1'b1, 1'b0, 32'hB00, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'hB00, 32'h0, 1'b1, 32'h1111_2222);
        @(negedge clk);
        rst = 1'b1; sram_ready = 1'b0;
        #1;
        check("mid_fill1_rd_en", 32'(sram_rd_en), 32'h1);
        @(negedge clk);
        rst = 1'b0; RD_EN = 1'b0;
        #1;
        m_reset();
        check("after_rst_ready", 32'(ready), 32'h1);
        check("after_rst_sram_en", 32'({sram_rd_en, sram_wr_en}), 32'h0);
        check_stats("after_rst");
        do_read(32'h100, 1);

        // Random traffic over a few sets and tags to provoke conflicts
        for (int n = 0; n < 150; n++) begin
            int op = $urandom_range(0, 5);
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 3) |
                (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
            if (op <= 2)      do_read(a, $urandom_range(1, 3));
            else if (op <= 4) do_write(a, $urandom, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            else              idle_cycle(1'($urandom_range(0, 1)));
        end
        idle_cycle(1'b0);
        check_stats("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
